// File: rtl/fetch_buffer_if.sv
// fetch_buffer_if: instruction-memory request/response bus and decode-side
// valid/ready handshake of the fetch buffer.
//   imem_req_o/imem_addr_o/imem_gnt_i        request channel (in-order)
//   imem_rvalid_i/imem_rdata_i               response channel (in-order)
//   id_valid_o/id_instr_o/id_pc_o/id_ready_i decode handshake
// Modports: master = fetch buffer side, slave = memory/decode side.
interface fetch_buffer_if #(
    parameter int XLEN = 32
);
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;
    logic            id_valid_o;
    logic [XLEN-1:0] id_instr_o;
    logic [XLEN-1:0] id_pc_o;
    logic            id_ready_i;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output id_valid_o, id_instr_o, id_pc_o,
        input  id_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  id_valid_o, id_instr_o, id_pc_o,
        output id_ready_i
    );
endinterface

// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction-fetch stage between the PC register and decode.
// Issues in-order requests for pc_i, pairs each response with its PC and
// queues the pair for decode. Requests are credit-limited so that queued
// plus live outstanding instructions never exceed DEPTH.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   pc_i      current PC from the PC register
//   stall_o   holds the PC register (low when a request is accepted or on flush)
//   flush_i   redirect pulse: clears queue, drops outstanding responses
//   bus       fetch_buffer_if.master (imem request/response, decode handshake)
// Optional feature macro: FETCH_BYPASS_EN -- when defined, a response that
// arrives while the queue is empty is presented to decode in the same cycle.
module fetch_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    output logic            stall_o,
    input  logic            flush_i,
    fetch_buffer_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef logic [AW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    // decode queue
    logic [XLEN-1:0] q_pc    [DEPTH];
    logic [XLEN-1:0] q_instr [DEPTH];
    ptr_t            q_rd, q_wr;
    cnt_t            q_cnt;

    // PCs of accepted requests awaiting their response
    logic [XLEN-1:0] p_pc [DEPTH];
    ptr_t            p_rd, p_wr;

    cnt_t inflight;   // all outstanding requests, old stream included
    cnt_t drop_cnt;   // outstanding requests belonging to a flushed stream

    cnt_t        live_inflight;
    logic [CW:0] credit_used;
    logic        req, accept, rsp_keep, q_empty, bypass, push, pop;

    always_comb begin
        live_inflight = inflight - drop_cnt;
        credit_used   = {1'b0, q_cnt} + {1'b0, live_inflight};
        req           = !rst && !flush_i && (credit_used < DEPTH_C);
        accept        = req && bus.imem_gnt_i;
        // Reset holds the PC; a flush must let the PC load the target.
        stall_o       = rst || (!flush_i && !accept);
        rsp_keep      = bus.imem_rvalid_i && (drop_cnt == '0) && !flush_i;
        q_empty       = (q_cnt == '0);
`ifdef FETCH_BYPASS_EN
        bypass        = !rst && rsp_keep && q_empty;
`else
        bypass        = 1'b0;
`endif
        pop           = !q_empty && bus.id_ready_i;
        // A bypassed response consumed this cycle never enters the queue.
        push          = rsp_keep && !(bypass && bus.id_ready_i);
    end

    assign bus.imem_req_o  = req;
    assign bus.imem_addr_o = pc_i;
    assign bus.id_valid_o  = !q_empty || bypass;
    assign bus.id_instr_o  = bypass ? bus.imem_rdata_i : q_instr[q_rd];
    assign bus.id_pc_o     = bypass ? p_pc[p_rd]       : q_pc[q_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
                p_pc[i]    <= '0;
            end
            q_rd     <= '0;
            q_wr     <= '0;
            q_cnt    <= '0;
            p_rd     <= '0;
            p_wr     <= '0;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            inflight <= inflight + cnt_t'(accept) - cnt_t'(bus.imem_rvalid_i);
            if (flush_i) begin
                // No request is accepted in a flush cycle, so everything
                // still outstanding after this edge belongs to the old stream.
                q_rd     <= '0;
                q_wr     <= '0;
                q_cnt    <= '0;
                p_rd     <= '0;
                p_wr     <= '0;
                drop_cnt <= inflight - cnt_t'(bus.imem_rvalid_i);
            end else begin
                if (bus.imem_rvalid_i && (drop_cnt != '0))
                    drop_cnt <= drop_cnt - cnt_t'(1);
                if (push) begin
                    q_pc[q_wr]    <= p_pc[p_rd];
                    q_instr[q_wr] <= bus.imem_rdata_i;
                    q_wr          <= q_wr + ptr_t'(1);
                end
                if (pop)
                    q_rd <= q_rd + ptr_t'(1);
                q_cnt <= q_cnt + cnt_t'(push) - cnt_t'(pop);
                if (accept) begin
                    p_pc[p_wr] <= pc_i;
                    p_wr       <= p_wr + ptr_t'(1);
                end
                if (rsp_keep)
                    p_rd <= p_rd + ptr_t'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: randomized bench for fetch_buffer. A queue-level model
// (decode queue of {pc,instr}, pending PCs, outstanding/drop counts), a PC
// register and an in-order memory with random latency live in the bench;
// one compare step checks every DUT output each cycle. Directed phases pin
// the model with hand-computed values.
module tb_fetch_buffer;
    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [XLEN-1:0] pc_i;
    logic            stall_o;
    logic            flush_i;

    fetch_buffer_if #(.XLEN(XLEN)) bus ();

    fetch_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .stall_o(stall_o),
        .flush_i(flush_i), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] mpend[$];
    int          m_infl, m_drop;
    logic [31:0] mem_addr[$];
    int          mem_due[$];
    ent_t        dec_log[$];
    int          cyc, first_valid_cyc;
    logic [31:0] pc;
    int          n_chk, n_fail;

    int          k_gnt, k_rdy, k_rv, k_lmin, k_lmax, k_flush;
    bit          force_flush;
    logic [31:0] flush_tgt;
    bit          s_req, s_stall;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic step();
        bit          fl, g, rdy, rv, e_req, acc, e_stall, byp, e_valid;
        logic [31:0] rd, e_pc, e_instr;
        ent_t        e;
        @(negedge clk);
        fl  = force_flush || ($urandom_range(99) < k_flush);
        g   = $urandom_range(99) < k_gnt;
        rdy = $urandom_range(99) < k_rdy;
        rv  = (mem_addr.size() > 0) && (mem_due[0] <= cyc) && ($urandom_range(99) < k_rv);
        rd  = rv ? mem_word(mem_addr[0]) : $urandom;
        if (fl && flush_tgt == 32'h0) flush_tgt = {$urandom_range(65535), 2'b00} & 32'hffff_fffc;
        flush_i           = fl;
        bus.imem_gnt_i    = g;
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rd;
        bus.id_ready_i    = rdy;
        pc_i              = pc;
        #1;
        e_req   = !fl && ((mq.size() + m_infl - m_drop) < DEPTH);
        acc     = e_req && g;
        e_stall = fl ? 1'b0 : !acc;
        byp     = 1'b0;
`ifdef FETCH_BYPASS_EN
        byp     = rv && (m_drop == 0) && !fl && (mq.size() == 0);
`endif
        e_valid = (mq.size() != 0) || byp;
        e_pc    = 32'h0;
        e_instr = 32'h0;
        if (byp) begin
            e_pc    = mpend[0];
            e_instr = rd;
        end else if (mq.size() != 0) begin
            e_pc    = mq[0].pc;
            e_instr = mq[0].instr;
        end
        s_req   = bus.imem_req_o;
        s_stall = stall_o;
        chk("imem_req", {31'b0, bus.imem_req_o}, {31'b0, e_req});
        chk("stall", {31'b0, stall_o}, {31'b0, e_stall});
        chk("id_valid", {31'b0, bus.id_valid_o}, {31'b0, e_valid});
        if (e_req) chk("imem_addr", bus.imem_addr_o, pc);
        if (e_valid) begin
            chk("id_pc", bus.id_pc_o, e_pc);
            chk("id_instr", bus.id_instr_o, e_instr);
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rdy) dec_log.push_back({e_pc, e_instr});
        end
        @(posedge clk);
        // model update for this edge
        if (rdy && mq.size() != 0) void'(mq.pop_front());
        if (rv) begin
            void'(mem_addr.pop_front());
            void'(mem_due.pop_front());
            m_infl--;
            if (m_drop > 0) m_drop--;
            else if (!fl) begin
                e.pc    = mpend.pop_front();
                e.instr = rd;
                if (!(byp && rdy)) mq.push_back(e);
            end
        end
        if (fl) begin
            mq.delete();
            mpend.delete();
            m_drop = m_infl;
        end
        if (acc) begin
            mpend.push_back(pc);
            m_infl++;
            mem_addr.push_back(pc);
            mem_due.push_back(cyc + $urandom_range(k_lmax, k_lmin));
        end
        if (fl) begin
            pc        = flush_tgt;
            flush_tgt = 32'h0;
        end else if (acc) pc = pc + 32'd4;
        cyc++;
    endtask

    task automatic set_knobs(input int g, input int r, input int v, input int lmin, input int lmax, input int f);
        k_gnt = g; k_rdy = r; k_rv = v; k_lmin = lmin; k_lmax = lmax; k_flush = f;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; first_valid_cyc = -1;
        m_infl = 0; m_drop = 0; pc = 32'h0; force_flush = 1'b0; flush_tgt = 32'h0;
        flush_i = 1'b0; pc_i = 32'h0;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = 32'h0; bus.id_ready_i = 1'b0;

        // reset state
        #2;
        chk("rst_req", {31'b0, bus.imem_req_o}, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd1);
        chk("rst_valid", {31'b0, bus.id_valid_o}, 32'd0);
        chk("rst_instr", bus.id_instr_o, 32'h0);
        chk("rst_pc", bus.id_pc_o, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // in-order fetch, grant every cycle, memory latency 1
        set_knobs(100, 100, 100, 1, 1, 0);
        repeat (8) step();
        chk("seq_n", dec_log.size() >= 3, 32'd1);
        if (dec_log.size() >= 3) begin
            chk("seq_pc0", dec_log[0].pc, 32'h0);
            chk("seq_in0", dec_log[0].instr, 32'h1357_9BDF);
            chk("seq_pc1", dec_log[1].pc, 32'h4);
            chk("seq_in1", dec_log[1].instr, 32'h1357_9BDB);
            chk("seq_pc2", dec_log[2].pc, 32'h8);
            chk("seq_in2", dec_log[2].instr, 32'h1357_9BD7);
        end
`ifdef FETCH_BYPASS_EN
        chk("first_latency", first_valid_cyc, 32'd1);
`else
        chk("first_latency", first_valid_cyc, 32'd2);
`endif

        // decode stalled: credits run out at DEPTH
        set_knobs(100, 0, 100, 1, 1, 0);
        repeat (12) step();
        chk("full_req", {31'b0, s_req}, 32'd0);
        chk("full_stall", {31'b0, s_stall}, 32'd1);
        chk("full_occ", mq.size(), DEPTH);
        k_rdy = 100;
        step();
        chk("pop_cycle_req", {31'b0, s_req}, 32'd0);
        k_rdy = 0;
        step();
        chk("after_pop_req", {31'b0, s_req}, 32'd1);
        step();
        chk("refull_req", {31'b0, s_req}, 32'd0);

        // grant withheld: PC held, stall high
        set_knobs(0, 100, 100, 1, 1, 0);
        repeat (3) begin
            step();
            chk("nogrant_stall", {31'b0, s_stall}, 32'd1);
        end

        // flush with requests in flight, redirect to 0x100
        set_knobs(100, 100, 100, 3, 3, 0);
        repeat (6) step();
        force_flush = 1'b1;
        flush_tgt   = 32'h100;
        step();
        force_flush = 1'b0;
        dec_log.delete();
        repeat (12) step();
        chk("flush_n", dec_log.size() >= 2, 32'd1);
        if (dec_log.size() >= 2) begin
            chk("flush_pc0", dec_log[0].pc, 32'h100);
            chk("flush_in0", dec_log[0].instr, 32'h1357_9ADF);
            chk("flush_pc1", dec_log[1].pc, 32'h104);
        end

        // random traffic with occasional redirects
        set_knobs(70, 60, 70, 1, 4, 3);
        repeat (3000) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
